// File: rtl/alu_result_checker.sv
// alu_result_checker: scores a stream of ALU-under-test vectors against a
// built-in golden ALU. Accepted vectors pass through a two-stage pipeline
// (input register, then compare outcome folded into the run counters). An FSM
// sequences IDLE -> RUN -> DRAIN -> DONE for each checking run.
module alu_result_checker #(
  parameter int unsigned N_VECTORS = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  input  logic [31:0] result,
  input  logic        zero,
  input  logic        carry,
  input  logic        negative,
  input  logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] vec_count,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_index,
  output logic [3:0]  first_fail_aluc,
  output logic [4:0]  first_fail_mask
);

  localparam logic [15:0] LAST_IDX   = 16'(N_VECTORS - 1);
  localparam logic [15:0] LAST_COUNT = 16'(N_VECTORS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic        accept;
  logic        clear_run;
  logic [15:0] acc_count;

  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [3:0]  s1_aluc;
  logic [31:0] s1_result;
  logic        s1_zero;
  logic        s1_carry;
  logic        s1_negative;
  logic        s1_overflow;

  logic [32:0]        sum33;
  logic [31:0]        diff;
  logic               borrow;
  logic signed [31:0] sra_val;
  logic [31:0]        exp_result;
  logic               exp_carry;
  logic               exp_overflow;
  logic               carry_used;
  logic               ovf_used;
  logic [4:0]         cmp_mask;

  assign accept    = in_valid && in_ready;
  // A new run may only be launched from IDLE or DONE; start elsewhere is ignored.
  assign clear_run = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign pass      = done && (err_count == 16'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: RUN ends on the last acceptance, DRAIN waits for the pipeline to empty.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_RUN;
      ST_RUN:   if (accept && (acc_count == LAST_IDX)) next_state = ST_DRAIN;
      ST_DRAIN: if (vec_count == LAST_COUNT) next_state = ST_DONE;
      ST_DONE:  if (start) next_state = ST_RUN;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_RUN:   begin in_ready = 1'b1; busy = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Count acceptances so RUN knows when the last vector of the run has been taken.
  always_ff @(posedge clk) begin
    if (rst || clear_run) acc_count <= 16'd0;
    else if (accept)      acc_count <= acc_count + 16'd1;
  end

  // Stage-1 valid bit; cleared by reset so in-flight vectors are discarded.
  always_ff @(posedge clk) begin
    if (rst || clear_run) s1_valid <= 1'b0;
    else                  s1_valid <= accept;
  end

  // Stage-1 data capture; payload is only meaningful while s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a        <= a;
      s1_b        <= b;
      s1_aluc     <= aluc;
      s1_result   <= result;
      s1_zero     <= zero;
      s1_carry    <= carry;
      s1_negative <= negative;
      s1_overflow <= overflow;
    end
  end

  assign sum33   = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff    = s1_a - s1_b;
  assign borrow  = s1_a < s1_b;
  assign sra_val = $signed(s1_b) >>> s1_a[4:0];

  // Golden ALU: expected result plus carry/overflow and which of them this opcode defines.
  always_comb begin
    exp_result   = 32'd0;
    exp_carry    = 1'b0;
    exp_overflow = 1'b0;
    carry_used   = 1'b0;
    ovf_used     = 1'b0;
    casez (s1_aluc)
      4'b0000: begin exp_result = sum33[31:0]; exp_carry = sum33[32]; carry_used = 1'b1; end
      4'b0001: begin exp_result = diff; exp_carry = borrow; carry_used = 1'b1; end
      4'b0010: begin
        exp_result   = sum33[31:0];
        exp_carry    = sum33[32];
        carry_used   = 1'b1;
        exp_overflow = (s1_a[31] == s1_b[31]) && (sum33[31] != s1_a[31]);
        ovf_used     = 1'b1;
      end
      4'b0011: begin
        exp_result   = diff;
        exp_carry    = borrow;
        carry_used   = 1'b1;
        exp_overflow = (s1_a[31] != s1_b[31]) && (diff[31] != s1_a[31]);
        ovf_used     = 1'b1;
      end
      4'b0100: exp_result = s1_a & s1_b;
      4'b0101: exp_result = s1_a | s1_b;
      4'b0110: exp_result = s1_a ^ s1_b;
      4'b0111: exp_result = ~(s1_a | s1_b);
      4'b100?: exp_result = {s1_b[15:0], 16'h0000};
      4'b1010: begin exp_result = {31'd0, borrow}; exp_carry = borrow; carry_used = 1'b1; end
      4'b1011: exp_result = {31'd0, $signed(s1_a) < $signed(s1_b)};
      4'b1100: exp_result = sra_val;
      4'b1101: exp_result = s1_b >> s1_a[4:0];
      4'b111?: exp_result = s1_b << s1_a[4:0];
      default: exp_result = 32'd0;
    endcase
  end

  // Per-field mismatch bits in {result,zero,carry,negative,overflow} order, undefined flags masked.
  always_comb begin
    cmp_mask = {s1_result != exp_result,
                s1_zero != (exp_result == 32'd0),
                carry_used && (s1_carry != exp_carry),
                s1_negative != exp_result[31],
                ovf_used && (s1_overflow != exp_overflow)};
  end

  // Stage 2: fold the compare outcome into the run counters and capture the first failure.
  always_ff @(posedge clk) begin
    if (rst || clear_run) begin
      vec_count        <= 16'd0;
      err_count        <= 16'd0;
      first_fail_index <= 16'd0;
      first_fail_aluc  <= 4'd0;
      first_fail_mask  <= 5'd0;
    end else if (s1_valid) begin
      vec_count <= vec_count + 16'd1;
      if (cmp_mask != 5'd0) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_fail_index <= vec_count;
          first_fail_aluc  <= s1_aluc;
          first_fail_mask  <= cmp_mask;
        end
      end
    end
  end

endmodule
